scs8hd_bufinv_seq: RTL and testbench
====================================

SCS8HD_BUFINV_SEQ -- requirements
Module: scs8hd_bufinv_seq

Interface
REQ-001 Parameter NSEG, default 4, is the number of independently enabled segments in the driven bufinv drive bank (legal 1..8).
REQ-002 Parameter STEP_CYC, default 4, is the number of CLK cycles between successive segment enable changes (legal 1..255).
REQ-003 Parameter LW, default 4, is the width of LEVEL; it SHALL be at least clog2(NSEG+1).
REQ-004 CLK  input  1  is the single clock; all state updates on its rising edge.
REQ-005 RESETB  input  1  is the reset: synchronous, active-low, sampled on the rising edge of CLK.
REQ-006 REQ  input  1  is the request for a new drive level; it is held high until ACK.
REQ-007 LEVEL  input  LW  is the target number of enabled segments; it is valid while REQ=1.
REQ-008 ACK  output  1  is a one-cycle pulse that accepts the request.
REQ-009 SEG_EN  output  NSEG  is the thermometer-coded segment enable; bit i drives segment i.
REQ-010 BUSY  output  1  is high while a level transition is in progress.
REQ-011 DONE  output  1  is a one-cycle pulse when SEG_EN equals the accepted target.

Function
REQ-012 The FSM SHALL have states IDLE, STEP and FIN, encoded one-hot or binary, and SHALL have no other reachable states.
REQ-013 In IDLE with REQ=1, the block SHALL latch tgt = min(LEVEL, NSEG) and go to STEP if tgt != cur, else FIN.
REQ-014 ACK SHALL be 1 for exactly the cycle after acceptance; REQ seen while BUSY=1 or in FIN SHALL be ignored with no ACK.
REQ-015 cur is the current enabled count and SHALL always equal popcount(SEG_EN), with SEG_EN = (1<<cur)-1.
REQ-016 Up step: cur increments by 1, so the lowest disabled segment turns on; down step: cur decrements by 1, so the highest enabled segment turns off.
REQ-017 The first step SHALL register on the same edge as ACK, and each later step exactly STEP_CYC cycles after the previous one, using a down-counter reloaded to STEP_CYC-1.
REQ-018 At most one SEG_EN bit SHALL change per clock edge, in every state.
REQ-019 STEP SHALL go to FIN on the edge that makes cur == tgt.
REQ-020 In FIN, DONE SHALL be 1 for one cycle, and the state SHALL return to IDLE on the next edge.
REQ-021 BUSY SHALL be 1 from the ACK cycle up to the cycle before DONE; it SHALL be 0 in IDLE and in the DONE cycle.
REQ-022 For a no-op request (tgt == cur), the DONE pulse SHALL coincide with the ACK pulse, SEG_EN SHALL not change, and BUSY SHALL stay 0.
REQ-023 For a transition of k steps, accepted at edge t, SEG_EN SHALL reach tgt at edge t+1+(k-1)*STEP_CYC, and DONE SHALL be high in the following cycle.
REQ-024 With STEP_CYC=1, the block SHALL step on every edge with no idle cycle between steps.
REQ-025 LEVEL and REQ changes after acceptance SHALL have no effect until the block returns to IDLE.

Reset
REQ-026 RESETB=0 at a rising edge SHALL force state IDLE, cur=0, tgt=0, counter=0, SEG_EN=0, ACK=0, BUSY=0 and DONE=0 on that edge.
REQ-027 Reset mid-transition SHALL disable all segments at once, without staggering, and the pending request SHALL be discarded with no DONE.
REQ-028 A REQ held high during reset SHALL be accepted on the first edge after RESETB returns to 1.

Verification (NSEG=4, STEP_CYC=4)
REQ-029 Reset, then REQ=1 with LEVEL=3 accepted at edge t -> SEG_EN is 0001@t+1, 0011@t+5, 0111@t+9; DONE is high in the cycle after t+9; BUSY is high from t+1 to t+9.
REQ-030 From SEG_EN=0111, REQ with LEVEL=1 -> SEG_EN steps 0011 then 0001, 4 cycles apart; one DONE pulse.
REQ-031 From SEG_EN=0011, REQ with LEVEL=2 -> ACK and DONE in the same cycle; SEG_EN stays 0011; BUSY stays 0.
REQ-032 REQ with LEVEL=9 -> clamped to 4, so SEG_EN ends at 1111 after 4 steps; a second REQ pulsed mid-sequence gets no ACK and does not alter the sequence.
REQ-033 RESETB=0 while SEG_EN=0111 and BUSY=1 -> on the next edge SEG_EN=0000 and BUSY=0, with no DONE.
REQ-034 STEP_CYC=1 build, LEVEL=4 from 0 -> SEG_EN changes on 4 consecutive edges; an assertion confirms at most one bit toggles per edge throughout.

Source files
------------

// File: rtl/scs8hd_bufinv_seq.sv
// scs8hd_bufinv_seq: staggered thermometer sequencer for a segmented bufinv drive bank
// Each accepted level is approached one segment at a time so supply steps stay small.
module scs8hd_bufinv_seq #(
  parameter int NSEG     = 4,
  parameter int STEP_CYC = 4,
  parameter int LW       = 4
) (
  input  logic            CLK,
  input  logic            RESETB,
  input  logic            REQ,
  input  logic [LW-1:0]   LEVEL,
  output logic            ACK,
  output logic [NSEG-1:0] SEG_EN,
  output logic            BUSY,
  output logic            DONE
);
  localparam int CW = $clog2(NSEG + 1);
  typedef enum logic [1:0] {IDLE, STEP, FIN} state_t;
  state_t          state_q;
  logic [CW-1:0]   cur_q, tgt_q, cur_d, lvl_d;
  logic [7:0]      cnt_q;
  logic            first_q, ack_q, busy_q, done_q;
  logic [NSEG-1:0] seg_q;
  assign lvl_d = (LEVEL > LW'(NSEG)) ? CW'(NSEG) : LEVEL[CW-1:0];
  assign cur_d = (tgt_q > cur_q) ? cur_q + 1'b1 : cur_q - 1'b1;
  // first_q marks the edge that owes the ACK: the first step, or FIN for a no-op
  always_ff @(posedge CLK) begin
    if (!RESETB) begin
      state_q <= IDLE;
      cur_q   <= '0;
      tgt_q   <= '0;
      cnt_q   <= '0;
      first_q <= 1'b0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      seg_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          ack_q  <= 1'b0;
          busy_q <= 1'b0;
          done_q <= 1'b0;
          if (REQ) begin
            tgt_q   <= lvl_d;
            first_q <= 1'b1;
            cnt_q   <= '0;
            state_q <= (lvl_d != cur_q) ? STEP : FIN;
          end
        end
        STEP: begin
          busy_q <= 1'b1;
          done_q <= 1'b0;
          if (cnt_q == 8'd0) begin
            cur_q   <= cur_d;
            seg_q   <= ~({NSEG{1'b1}} << cur_d);
            cnt_q   <= 8'(STEP_CYC - 1);
            ack_q   <= first_q;
            first_q <= 1'b0;
            if (cur_d == tgt_q) state_q <= FIN;
          end else begin
            cnt_q <= cnt_q - 8'd1;
            ack_q <= 1'b0;
          end
        end
        FIN: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          ack_q   <= first_q;
          first_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign ACK    = ack_q;
  assign SEG_EN = seg_q;
  assign BUSY   = busy_q;
  assign DONE   = done_q;
endmodule

// File: tb/tb_scs8hd_bufinv_seq.sv
// tb_scs8hd_bufinv_seq: directed checks of the staggered segment sequencer
// u4 uses STEP_CYC=4, u1 uses STEP_CYC=1; both share clock and reset.
module tb_scs8hd_bufinv_seq;
  logic       clk = 1'b0, rstn = 1'b0;
  logic       req = 1'b0, req1 = 1'b0;
  logic [3:0] level = '0, level1 = '0;
  logic       ack4, busy4, done4, ack1, busy1, done1;
  logic [3:0] seg4, seg1;
  int         checks = 0, errors = 0;

  scs8hd_bufinv_seq #(.NSEG(4), .STEP_CYC(4), .LW(4)) u4 (
    .CLK(clk), .RESETB(rstn), .REQ(req), .LEVEL(level),
    .ACK(ack4), .SEG_EN(seg4), .BUSY(busy4), .DONE(done4));
  scs8hd_bufinv_seq #(.NSEG(4), .STEP_CYC(1), .LW(4)) u1 (
    .CLK(clk), .RESETB(rstn), .REQ(req1), .LEVEL(level1),
    .ACK(ack1), .SEG_EN(seg1), .BUSY(busy1), .DONE(done1));

  always #5 clk = ~clk;

  // at most one segment may toggle per non-reset edge, in both builds
  logic [3:0] p4 = '0, p1 = '0;
  logic       r_at_edge;
  always @(posedge clk) begin
    r_at_edge = rstn;
    #1;
    if (r_at_edge) begin
      checks += 2;
      if ($countones(seg4 ^ p4) > 1) begin
        errors++; $display("FAIL toggle4 got %b after %b, need at most one bit change", seg4, p4);
      end
      if ($countones(seg1 ^ p1) > 1) begin
        errors++; $display("FAIL toggle1 got %b after %b, need at most one bit change", seg1, p1);
      end
    end
    p4 = seg4;
    p1 = seg1;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    cyc();
    cyc();
    checks++;
    if ({ack4, busy4, done4, seg4} !== 7'b0) begin
      errors++; $display("FAIL reset4 got %b need 0000000", {ack4, busy4, done4, seg4});
    end
    checks++;
    if ({ack1, busy1, done1, seg1} !== 7'b0) begin
      errors++; $display("FAIL reset1 got %b need 0000000", {ack1, busy1, done1, seg1});
    end
    rstn = 1'b1;
  endtask

  task automatic test_transition(input string nm, input logic [3:0] lvl, input int from, input bit poke);
    int tgt, k, last, n, cur;
    logic [6:0] exp, got;
    tgt = (lvl > 4) ? 4 : int'(lvl);
    k = (tgt > from) ? tgt - from : from - tgt;
    last = 1 + (k - 1) * 4;
    req = 1'b1;
    level = lvl;
    cyc();
    checks++;
    if (ack4 !== 1'b0) begin
      errors++; $display("FAIL %s_accept ack got %b need 0", nm, ack4);
    end
    for (int i = 1; i <= last + 1; i++) begin
      cyc();
      n = (i - 1) / 4 + 1;
      if (n > k) n = k;
      cur = (tgt > from) ? from + n : from - n;
      exp = {i == 1, i <= last, i == last + 1, 4'((1 << cur) - 1)};
      got = {ack4, busy4, done4, seg4};
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL %s_cyc%0d ack/busy/done/seg got %b need %b", nm, i, got, exp);
      end
      if (i == 1) begin req = 1'b0; level = 4'd0; end
      if (poke && i == 6) begin req = 1'b1; level = 4'd1; end
      if (poke && i == 8) req = 1'b0;
    end
    cyc();
    checks++;
    if ({ack4, busy4, done4, seg4} !== {3'b000, 4'((1 << tgt) - 1)}) begin
      errors++; $display("FAIL %s_idle got %b need %b", nm, {ack4, busy4, done4, seg4}, {3'b000, 4'((1 << tgt) - 1)});
    end
  endtask

  task automatic test_noop();
    req = 1'b1;
    level = 4'd2;
    cyc();
    checks++;
    if ({ack4, busy4, done4, seg4} !== 7'b000_0011) begin
      errors++; $display("FAIL noop_accept got %b need 0000011", {ack4, busy4, done4, seg4});
    end
    cyc();
    checks++;
    if ({ack4, busy4, done4, seg4} !== 7'b101_0011) begin
      errors++; $display("FAIL noop_ackdone got %b need 1010011", {ack4, busy4, done4, seg4});
    end
    req = 1'b0;
    cyc();
    checks++;
    if ({ack4, busy4, done4, seg4} !== 7'b000_0011) begin
      errors++; $display("FAIL noop_after got %b need 0000011", {ack4, busy4, done4, seg4});
    end
  endtask

  task automatic test_mid_reset();
    req = 1'b1;
    level = 4'd0;
    cyc();
    cyc();
    checks++;
    if ({ack4, busy4, done4, seg4} !== 7'b110_0111) begin
      errors++; $display("FAIL midrst_pre got %b need 1100111", {ack4, busy4, done4, seg4});
    end
    req = 1'b0;
    rstn = 1'b0;
    cyc();
    checks++;
    if ({ack4, busy4, done4, seg4} !== 7'b0) begin
      errors++; $display("FAIL midrst_edge got %b need 0000000", {ack4, busy4, done4, seg4});
    end
    rstn = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cyc();
      checks++;
      if ({done4, seg4} !== 5'b0) begin
        errors++; $display("FAIL midrst_quiet%0d done/seg got %b need 00000", i, {done4, seg4});
      end
    end
  endtask

  task automatic test_req_in_reset();
    int waited;
    rstn = 1'b0;
    req = 1'b1;
    level = 4'd2;
    cyc();
    cyc();
    rstn = 1'b1;
    cyc();
    checks++;
    if ({ack4, seg4} !== 5'b0) begin
      errors++; $display("FAIL rstreq_accept ack/seg got %b need 00000", {ack4, seg4});
    end
    cyc();
    checks++;
    if ({ack4, busy4, seg4} !== 6'b11_0001) begin
      errors++; $display("FAIL rstreq_ack ack/busy/seg got %b need 110001", {ack4, busy4, seg4});
    end
    req = 1'b0;
    waited = 0;
    while (done4 !== 1'b1 && waited < 20) begin
      cyc();
      waited++;
    end
    checks++;
    if (done4 !== 1'b1 || seg4 !== 4'b0011) begin
      errors++; $display("FAIL rstreq_done done/seg got %b/%b need 1/0011 within 20 cycles", done4, seg4);
    end
    cyc();
  endtask

  task automatic test_fast();
    logic [6:0] exp;
    req1 = 1'b1;
    level1 = 4'd4;
    cyc();
    for (int i = 1; i <= 5; i++) begin
      cyc();
      exp = {i == 1, i <= 4, i == 5, 4'((1 << ((i > 4) ? 4 : i)) - 1)};
      checks++;
      if ({ack1, busy1, done1, seg1} !== exp) begin
        errors++; $display("FAIL fast_cyc%0d got %b need %b", i, {ack1, busy1, done1, seg1}, exp);
      end
      if (i == 1) req1 = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_transition("up3", 4'd3, 0, 1'b0);
    test_transition("down1", 4'd1, 3, 1'b0);
    test_transition("up2", 4'd2, 1, 1'b0);
    test_noop();
    test_transition("down0", 4'd0, 2, 1'b0);
    test_transition("clamp9", 4'd9, 0, 1'b1);
    test_mid_reset();
    test_req_in_reset();
    test_fast();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
